// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux vector sequencer: state encoding,
// sweep length and the expected-value rule of a 2:1 mux.
package mux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int unsigned VEC_COUNT = 8;
  localparam int unsigned VEC_W     = 3;

  // Vector layout is {S,A,B}; a correct mux returns A when S=0, B when S=1.
  function automatic logic expected_z(input logic [VEC_W-1:0] vec);
    return vec[2] ? vec[0] : vec[1];
  endfunction

endpackage

// File: rtl/mux_seq_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps to 0 after the
// terminal count, and is forced to 0 by a clear.
module mux_seq_dwell_timer #(
  parameter int unsigned DWELL = 25
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] TC_VAL = 8'(DWELL - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tc_o = (cnt_q == TC_VAL);

  // Next count: clear wins, otherwise advance and wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      if (tc_o) begin
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_vector_sequencer.sv
// Mux vector sequencer: sweeps {S,A,B} through 0..7 holding each vector
// for DWELL cycles, samples the returned Z at the end of each dwell and
// counts mismatches against the ideal 2:1 mux behaviour.
module mux_vector_sequencer #(
  parameter int unsigned DWELL = 25,
  parameter int unsigned ERR_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             Z,
  output logic             S,
  output logic             A,
  output logic             B,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT
);

  import mux_seq_pkg::*;

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(VEC_COUNT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] sab_q, sab_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             busy_q, done_q;
  logic             tc_s;
  logic             sample_s;
  logic             mismatch_s;
  logic [ERR_W-1:0] err_next_s;

  mux_seq_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (state_q != DRIVE),
    .en_i   (state_q == DRIVE),
    .tc_o   (tc_s)
  );

  // Z only reaches registers: it is compared against the vector currently held.
  assign sample_s   = (state_q == DRIVE) && tc_s;
  assign mismatch_s = (Z != expected_z(idx_q));
  assign err_next_s = (sample_s && mismatch_s && (err_q != ERR_MAX))
                      ? (err_q + ERR_W'(1)) : err_q;

  // Next-state and datapath update for the sweep FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = DRIVE;
          idx_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        err_d = err_next_s;
        if (tc_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
            pass_d  = (err_next_s == '0);
          end else begin
            idx_d = idx_q + VEC_W'(1);
          end
        end else begin
          state_d = DRIVE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    sab_d = (state_d == DRIVE) ? idx_d : '0;
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sab_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sab_q   <= sab_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FINISH);
    end
  end

  assign S       = sab_q[2];
  assign A       = sab_q[1];
  assign B       = sab_q[0];
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PASS    = pass_q;
  assign ERR_CNT = err_q;

endmodule
